// File: rtl/sc_param_loader.sv
// ----------------------------------------------------------------------------
// sc_param_loader
// Slow-control loader for the SKIROC2 chip, fed by the S-curve parameter scan.
// A start pulse latches a frame made of the static base configuration with
// the scan's trigger mask and threshold DAC overlaid. The frame is shifted MSB
// first into the SC chain. It can be shifted a second time so the readback can
// be compared. Load_SC is then strobed and a one-cycle Sc_End is returned.
//
// Bit numbering: frame bit i (1..SC_LEN) is stored at vector index i-1.
// Likewise, mask/DAC/base bit k (counted from 1) is port index k-1.
// All chip-facing outputs are registered. They are computed from the state
// being entered, so each output is valid during the same cycle as its state.
// ----------------------------------------------------------------------------
module sc_param_loader #(
  parameter int SC_LEN   = 616,
  parameter int MASK_LSB = 100,
  parameter int DAC_LSB  = 400,
  parameter int LOAD_CYC = 4,
  parameter int VERIFY   = 1
) (
  input  logic              Clk_10M,
  input  logic              Rst_N,
  input  logic              In_Set_SC,
  input  logic [63:0]       In_Mask_Code,
  input  logic [11:0]       In_DAC_Code,
  input  logic [SC_LEN-1:0] In_Base_Config,
  input  logic              In_Sr_Out,
  output logic              Out_Sr_Ck,
  output logic              Out_Sr_In,
  output logic              Out_Load_Sc,
  output logic              Out_Busy,
  output logic              Out_Sc_End,
  output logic              Out_Sc_Err
);

  localparam int CNT_W  = $clog2(SC_LEN);
  localparam int LOAD_W = (LOAD_CYC > 1) ? $clog2(LOAD_CYC) : 1;

  localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(SC_LEN - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [LOAD_W-1:0] LAST_LOAD = LOAD_W'(LOAD_CYC - 1);
  localparam logic [LOAD_W-1:0] LOAD_ONE  = LOAD_W'(1);
  localparam logic              VERIFY_EN = (VERIFY != 0);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LATCH   = 3'd1,
    ST_SHIFT_A = 3'd2,
    ST_SHIFT_B = 3'd3,
    ST_LOAD    = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  state_t              state_r;
  state_t              state_s;
  logic [CNT_W-1:0]    bit_cnt_r;
  logic [CNT_W-1:0]    bit_cnt_s;
  logic [LOAD_W-1:0]   load_cnt_r;
  logic [LOAD_W-1:0]   load_cnt_s;
  logic                pass_r;
  logic                pass_s;
  logic [SC_LEN-1:0]   frame_r;
  logic [SC_LEN-1:0]   frame_s;
  logic                tx_bit_s;
  logic                exp_bit_s;
  logic                mismatch_s;

  logic                sr_ck_r;
  logic                sr_in_r;
  logic                load_sc_r;
  logic                busy_r;
  logic                sc_end_r;
  logic                sc_err_r;

  // Frame assembly: base config, then DAC, then mask (the mask wins on overlap)
  always_comb begin
    frame_s                    = In_Base_Config;
    frame_s[DAC_LSB-1 +: 12]   = In_DAC_Code;
    frame_s[MASK_LSB-1 +: 64]  = In_Mask_Code;
  end

  // The bit about to be driven uses the next count; the readback compare uses
  // the count of the SHIFT_A cycle now in progress.
  assign tx_bit_s   = frame_r[LAST_BIT - bit_cnt_s];
  assign exp_bit_s  = frame_r[LAST_BIT - bit_cnt_r];
  assign mismatch_s = (state_r == ST_SHIFT_A) && pass_r && (In_Sr_Out != exp_bit_s);

  // Next-state and counter logic for the load sequence
  always_comb begin
    state_s    = state_r;
    bit_cnt_s  = bit_cnt_r;
    load_cnt_s = load_cnt_r;
    pass_s     = pass_r;
    case (state_r)
      ST_IDLE: begin
        if (In_Set_SC) begin
          state_s = ST_LATCH;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LATCH: begin
        bit_cnt_s  = '0;
        load_cnt_s = '0;
        pass_s     = 1'b0;
        state_s    = ST_SHIFT_A;
      end
      ST_SHIFT_A: begin
        state_s = ST_SHIFT_B;
      end
      ST_SHIFT_B: begin
        if (bit_cnt_r == LAST_BIT) begin
          bit_cnt_s = '0;
          if (VERIFY_EN && !pass_r) begin
            pass_s  = 1'b1;
            state_s = ST_SHIFT_A;
          end else begin
            load_cnt_s = '0;
            state_s    = ST_LOAD;
          end
        end else begin
          bit_cnt_s = bit_cnt_r + CNT_ONE;
          state_s   = ST_SHIFT_A;
        end
      end
      ST_LOAD: begin
        if (load_cnt_r == LAST_LOAD) begin
          state_s = ST_DONE;
        end else begin
          load_cnt_s = load_cnt_r + LOAD_ONE;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, counters and pass flag; reset aborts any load in progress
  always_ff @(posedge Clk_10M or negedge Rst_N) begin
    if (!Rst_N) begin
      state_r    <= ST_IDLE;
      bit_cnt_r  <= '0;
      load_cnt_r <= '0;
      pass_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      bit_cnt_r  <= bit_cnt_s;
      load_cnt_r <= load_cnt_s;
      pass_r     <= pass_s;
    end
  end

  // Frame capture on the way into LATCH; inputs are ignored after this
  always_ff @(posedge Clk_10M or negedge Rst_N) begin
    if (!Rst_N) begin
      frame_r <= '0;
    end else if (state_s == ST_LATCH) begin
      frame_r <= frame_s;
    end else begin
      frame_r <= frame_r;
    end
  end

  // Registered chip interface and status, decoded from the state being entered
  always_ff @(posedge Clk_10M or negedge Rst_N) begin
    if (!Rst_N) begin
      sr_ck_r   <= 1'b0;
      sr_in_r   <= 1'b0;
      load_sc_r <= 1'b0;
      busy_r    <= 1'b0;
      sc_end_r  <= 1'b0;
    end else begin
      // Clock low while data changes, high for the second half of each bit
      sr_ck_r   <= (state_s == ST_SHIFT_B);
      if (state_s == ST_SHIFT_A) begin
        sr_in_r <= tx_bit_s;
      end else if (state_s == ST_SHIFT_B) begin
        sr_in_r <= sr_in_r;
      end else begin
        sr_in_r <= 1'b0;
      end
      load_sc_r <= (state_s == ST_LOAD);
      busy_r    <= (state_s != ST_IDLE);
      sc_end_r  <= (state_s == ST_DONE);
    end
  end

  // Sticky readback error: cleared at each start, set by any mismatch
  always_ff @(posedge Clk_10M or negedge Rst_N) begin
    if (!Rst_N) begin
      sc_err_r <= 1'b0;
    end else if (state_s == ST_LATCH) begin
      sc_err_r <= 1'b0;
    end else if (mismatch_s) begin
      sc_err_r <= 1'b1;
    end else begin
      sc_err_r <= sc_err_r;
    end
  end

  assign Out_Sr_Ck   = sr_ck_r;
  assign Out_Sr_In   = sr_in_r;
  assign Out_Load_Sc = load_sc_r;
  assign Out_Busy    = busy_r;
  assign Out_Sc_End  = sc_end_r;
  assign Out_Sc_Err  = sc_err_r;

  sc_param_loader_chk u_chk (
    .Clk_10M     (Clk_10M),
    .Rst_N       (Rst_N),
    .Out_Sr_Ck   (sr_ck_r),
    .Out_Load_Sc (load_sc_r),
    .Out_Busy    (busy_r),
    .Out_Sc_End  (sc_end_r)
  );

endmodule

// ----------------------------------------------------------------------------
// sc_param_loader_chk
// Protocol properties of the loader's chip-facing outputs.
// ----------------------------------------------------------------------------
module sc_param_loader_chk (
  input logic Clk_10M,
  input logic Rst_N,
  input logic Out_Sr_Ck,
  input logic Out_Load_Sc,
  input logic Out_Busy,
  input logic Out_Sc_End
);

  // Completion is a single-cycle pulse
  a_end_single: assert property (@(posedge Clk_10M) disable iff (!Rst_N)
    Out_Sc_End |=> !Out_Sc_End);

  // Shift clock only runs inside a busy sequence
  a_ck_busy: assert property (@(posedge Clk_10M) disable iff (!Rst_N)
    Out_Sr_Ck |-> Out_Busy);

  // Load strobe only inside a busy sequence, never together with a shift clock
  a_load_busy: assert property (@(posedge Clk_10M) disable iff (!Rst_N)
    Out_Load_Sc |-> (Out_Busy && !Out_Sr_Ck));

endmodule

// File: tb/tb_sc_param_loader.sv
// ----------------------------------------------------------------------------
// tb_sc_param_loader
// Two loaders (with and without readback) drive behavioural SC-chain models.
// Each start pushes the hand-computed expected result into a per-DUT queue.
// A monitor per DUT pops and compares the queue whenever Sc_End is presented.
// Frame expectations use 1-based bit numbers, so chain/vector index = bit-1.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sc_param_loader;

  localparam int SC_LEN   = 616;
  localparam int LOAD_CYC = 4;
  localparam logic [SC_LEN-1:0] FLIP_MASK = {{(SC_LEN-1){1'b0}}, 1'b1} << 499;

  typedef struct {
    int                start_cyc;
    int                lat;
    logic              err;
    logic [SC_LEN-1:0] frame;
    int                rise_base;
    int                rises;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              set_v = 1'b0;
  logic              set_s = 1'b0;
  logic [63:0]       mask = '0;
  logic [11:0]       dac = '0;
  logic [SC_LEN-1:0] base = '0;

  logic sr_ck_v, sr_in_v, load_v, busy_v, end_v, err_v;
  logic sr_ck_s, sr_in_s, load_s, busy_s, end_s, err_s;
  logic sr_out_v, sr_out_s;

  logic [SC_LEN-1:0] chain_v = '0;
  logic [SC_LEN-1:0] chain_s = '0;
  int rises_v = 0;
  int rises_s = 0;
  int flip_at_v = -1;
  int run_v = 0;
  int run_s = 0;
  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;

  exp_t q_v[$];
  exp_t q_s[$];

  always #50 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  sc_param_loader #(.VERIFY(1)) u_dut_v (
    .Clk_10M(clk), .Rst_N(rst_n), .In_Set_SC(set_v), .In_Mask_Code(mask),
    .In_DAC_Code(dac), .In_Base_Config(base), .In_Sr_Out(sr_out_v),
    .Out_Sr_Ck(sr_ck_v), .Out_Sr_In(sr_in_v), .Out_Load_Sc(load_v),
    .Out_Busy(busy_v), .Out_Sc_End(end_v), .Out_Sc_Err(err_v)
  );

  sc_param_loader #(.VERIFY(0)) u_dut_s (
    .Clk_10M(clk), .Rst_N(rst_n), .In_Set_SC(set_s), .In_Mask_Code(mask),
    .In_DAC_Code(dac), .In_Base_Config(base), .In_Sr_Out(sr_out_s),
    .Out_Sr_Ck(sr_ck_s), .Out_Sr_In(sr_in_s), .Out_Load_Sc(load_s),
    .Out_Busy(busy_s), .Out_Sc_End(end_s), .Out_Sc_Err(err_s)
  );

  // Behavioural SC chains: shift on the rising shift clock, output = last stage
  assign sr_out_v = chain_v[SC_LEN-1];
  assign sr_out_s = chain_s[SC_LEN-1];

  always @(posedge sr_ck_v) begin
    chain_v <= {chain_v[SC_LEN-2:0], sr_in_v} ^ (((rises_v + 1) == flip_at_v) ? FLIP_MASK : '0);
    rises_v <= rises_v + 1;
  end

  always @(posedge sr_ck_s) begin
    chain_s <= {chain_s[SC_LEN-2:0], sr_in_s};
    rises_s <= rises_s + 1;
  end

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, req);
  endfunction

  function automatic void chk_frame(input string name, input logic [SC_LEN-1:0] act,
                                    input logic [SC_LEN-1:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, req);
  endfunction

  // Ones at 1-based frame bits lo..hi
  function automatic logic [SC_LEN-1:0] ones(input int lo, input int hi);
    logic [SC_LEN-1:0] f;
    f = '0;
    for (int i = lo; i <= hi; i++) f[i-1] = 1'b1;
    return f;
  endfunction

  function automatic exp_t mk(input int lat, input logic err, input logic [SC_LEN-1:0] f,
                              input int rises);
    exp_t e;
    e.start_cyc = 0;
    e.lat       = lat;
    e.err       = err;
    e.frame     = f;
    e.rise_base = 0;
    e.rises     = rises;
    return e;
  endfunction

  task automatic check_entry(input string tag, input exp_t e, input int now,
                             input logic [SC_LEN-1:0] chain, input int rises,
                             input logic err, input logic busy, input logic load_now,
                             input int run);
    chk({tag, "_latency"}, 64'(now - e.start_cyc), 64'(e.lat));
    chk({tag, "_err"}, {63'd0, err}, {63'd0, e.err});
    chk({tag, "_sr_ck_rises"}, 64'(rises - e.rise_base), 64'(e.rises));
    chk({tag, "_busy_at_end"}, {63'd0, busy}, 64'd1);
    chk({tag, "_load_width"}, 64'(run), 64'(LOAD_CYC));
    chk({tag, "_load_off_at_end"}, {63'd0, load_now}, 64'd0);
    chk_frame({tag, "_chain_frame"}, chain, e.frame);
  endtask

  // Monitor for the readback loader
  always @(negedge clk) begin
    if (rst_n && end_v) begin
      if (q_v.size() == 0) begin
        chk("v_unexpected_sc_end", 64'd1, 64'd0);
      end else begin
        check_entry("v", q_v[0], cyc, chain_v, rises_v, err_v, busy_v, load_v, run_v);
        void'(q_v.pop_front());
      end
    end
    run_v <= load_v ? run_v + 1 : 0;
  end

  // Monitor for the single-pass loader
  always @(negedge clk) begin
    if (rst_n && end_s) begin
      if (q_s.size() == 0) begin
        chk("s_unexpected_sc_end", 64'd1, 64'd0);
      end else begin
        check_entry("s", q_s[0], cyc, chain_s, rises_s, err_s, busy_s, load_s, run_s);
        void'(q_s.pop_front());
      end
    end
    run_s <= load_s ? run_s + 1 : 0;
  end

  // One-cycle start pulse; optionally registers the expected result
  task automatic start(input bit which_s, input exp_t e, input bit push);
    @(posedge clk);
    #1;
    e.start_cyc = cyc;
    if (which_s) begin
      e.rise_base = rises_s;
      if (push) q_s.push_back(e);
      set_s = 1'b1;
    end else begin
      e.rise_base = rises_v;
      if (push) q_v.push_back(e);
      set_v = 1'b1;
    end
    @(posedge clk);
    #1;
    set_v = 1'b0;
    set_s = 1'b0;
  endtask

  task automatic wait_empty(input bit which_s, input int budget);
    for (int i = 0; i < budget; i++) begin
      if ((which_s ? q_s.size() : q_v.size()) == 0) break;
      @(posedge clk);
    end
    if (which_s) begin
      chk("s_sc_end_seen", 64'(q_s.size()), 64'd0);
      q_s.delete();
    end else begin
      chk("v_sc_end_seen", 64'(q_v.size()), 64'd0);
      q_v.delete();
    end
  endtask

  logic [SC_LEN-1:0] exp1;
  logic [SC_LEN-1:0] exp3;

  initial begin
    // Mask 7FFF..: bits 100..162 set, 163 clear; DAC 0FA: bits 401, 403..407
    exp1 = ones(100, 162) | ones(401, 401) | ones(403, 407);
    // All-ones mask and DAC
    exp3 = ones(100, 163) | ones(400, 411);

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("v_reset_outputs", {58'd0, sr_ck_v, sr_in_v, load_v, busy_v, end_v, err_v}, 64'd0);
    chk("s_reset_outputs", {58'd0, sr_ck_s, sr_in_s, load_s, busy_s, end_s, err_s}, 64'd0);
    rst_n = 1'b1;

    // Nominal load with readback
    mask = 64'h7FFF_FFFF_FFFF_FFFF;
    dac  = 12'h0FA;
    base = '0;
    start(1'b0, mk(2470, 1'b0, exp1, 1232), 1'b1);
    wait_empty(1'b0, 2600);
    chk("v_dac_bits_411_400", {52'd0, chain_v[410:399]}, 64'h0FA);

    // Chain corrupts frame bit 500 between passes
    flip_at_v = rises_v + SC_LEN;
    start(1'b0, mk(2470, 1'b1, exp1, 1232), 1'b1);
    wait_empty(1'b0, 2600);
    flip_at_v = -1;
    repeat (5) @(posedge clk);
    #1;
    chk("v_err_sticky", {63'd0, err_v}, 64'd1);

    // Boundary pattern, plus a second start pulse while busy
    mask = 64'hFFFF_FFFF_FFFF_FFFF;
    dac  = 12'hFFF;
    start(1'b0, mk(2470, 1'b0, exp3, 1232), 1'b1);
    chk("v_err_clear_in_latch", {63'd0, err_v}, 64'd0);
    chk("v_busy_in_latch", {63'd0, busy_v}, 64'd1);
    repeat (98) @(posedge clk);
    #1;
    set_v = 1'b1;
    @(posedge clk);
    #1;
    set_v = 1'b0;
    wait_empty(1'b0, 2600);
    repeat (10) @(posedge clk);
    #1;
    chk("v_no_restart", {63'd0, busy_v}, 64'd0);

    // Single pass; DAC changes mid-shift must not reach the chain
    mask = 64'h7FFF_FFFF_FFFF_FFFF;
    dac  = 12'h0FA;
    start(1'b1, mk(1238, 1'b0, exp1, 616), 1'b1);
    repeat (300) @(posedge clk);
    #1;
    dac = 12'h123;
    wait_empty(1'b1, 1400);

    // Reset during a load aborts it with no Sc_End
    mask = 64'h0;
    dac  = 12'h0;
    base = '1;
    start(1'b0, mk(2470, 1'b0, '0, 1232), 1'b0);
    repeat (698) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("v_reset_mid_shift", {58'd0, sr_ck_v, sr_in_v, load_v, busy_v, end_v, err_v}, 64'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Fresh load after the abort: base ones everywhere except mask/DAC fields
    start(1'b0, mk(2470, 1'b0, ~exp3, 1232), 1'b1);
    wait_empty(1'b0, 2600);

    repeat (20) @(posedge clk);
    #1;
    chk("queues_drained", 64'(q_v.size() + q_s.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
